// File: rtl/esc_ping_pkg.sv
// Shared types and constants for the escalation ping scheduler.
package esc_ping_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StPing = 2'd2
  } state_e;

  localparam logic [15:0] LfsrPoly        = 16'hB400;
  localparam logic [15:0] LfsrDefaultSeed = 16'hACE1;

endpackage

// File: rtl/esc_ping_lfsr.sv
// 16-bit Galois LFSR; advances once per enabled cycle and never locks at zero.
module esc_ping_lfsr
  import esc_ping_pkg::*;
#(
  parameter logic [15:0] Seed = LfsrDefaultSeed
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // next-state: shift right, fold polynomial in when the dropped bit is set
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrPoly : 16'h0000);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/esc_ping_timer.sv
// Round-robin ping scheduler: random wait, one-hot ping, acknowledge or timeout.
module esc_ping_timer
  import esc_ping_pkg::*;
#(
  parameter int unsigned NumTargets = 4,
  parameter int unsigned TimeoutW   = 16,
  parameter int unsigned WaitW      = 16,
  parameter int unsigned MinWait    = 8,
  parameter int unsigned RandWaitW  = 4,
  parameter logic [15:0] LfsrSeed   = LfsrDefaultSeed,
  localparam int unsigned IdxW      = $clog2(NumTargets)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  wait_rand_en_i,
  input  logic [TimeoutW-1:0]   timeout_cyc_i,
  output logic [NumTargets-1:0] ping_req_o,
  input  logic [NumTargets-1:0] ping_ok_i,
  output logic                  ping_fail_o,
  output logic [IdxW-1:0]       fail_idx_o,
  output logic                  spurious_o,
  output logic                  busy_o
);

  function automatic logic [NumTargets-1:0] onehot(input logic [IdxW-1:0] idx);
    logic [NumTargets-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d, idx_next, fail_idx_q, fail_idx_d;
  logic [WaitW-1:0]      cnt_q, cnt_d, wait_len;
  logic [TimeoutW-1:0]   tmo_q, tmo_d, tmo_last;
  logic [NumTargets-1:0] req_q, req_d, active_vec;
  logic                  busy_q, fail_q, fail_d, spur_q, spur_d;
  logic [15:0]           lfsr_state;
  logic                  unused_lfsr_bits;

  esc_ping_lfsr #(
    .Seed (LfsrSeed)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (en_i),
    .state_o (lfsr_state)
  );

  assign unused_lfsr_bits = ^lfsr_state[15:RandWaitW];

  // wait length, timeout limit (0 behaves as 1) and wrapped index
  always_comb begin
    wait_len = WaitW'(MinWait);
    if (wait_rand_en_i) begin
      wait_len = WaitW'(MinWait) + WaitW'(lfsr_state[RandWaitW-1:0]);
    end else begin
      wait_len = WaitW'(MinWait);
    end
    tmo_last = '0;
    if (timeout_cyc_i == '0) begin
      tmo_last = '0;
    end else begin
      tmo_last = timeout_cyc_i - TimeoutW'(1);
    end
    idx_next = '0;
    if (idx_q == IdxW'(NumTargets - 1)) begin
      idx_next = '0;
    end else begin
      idx_next = idx_q + IdxW'(1);
    end
  end

  // FSM next state, counters and registered-output inputs
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    fail_d     = 1'b0;
    fail_idx_d = fail_idx_q;
    if (!en_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          cnt_d   = wait_len;
          state_d = StWait;
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_d = StPing;
            tmo_d   = '0;
          end else begin
            cnt_d = cnt_q - WaitW'(1);
          end
        end
        StPing: begin
          if (ping_ok_i[idx_q]) begin
            idx_d   = idx_next;
            cnt_d   = wait_len;
            state_d = StWait;
          end else if (tmo_q == tmo_last) begin
            fail_d     = 1'b1;
            fail_idx_d = idx_q;
            idx_d      = idx_next;
            cnt_d      = wait_len;
            state_d    = StWait;
          end else begin
            tmo_d = tmo_q + TimeoutW'(1);
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    active_vec = '0;
    if (state_q == StPing) begin
      active_vec = onehot(idx_q);
    end else begin
      active_vec = '0;
    end
    spur_d = |(ping_ok_i & ~active_vec);

    req_d = '0;
    if (state_d == StPing) begin
      req_d = onehot(idx_d);
    end else begin
      req_d = '0;
    end
  end

  // state, counters and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      req_q      <= '0;
      busy_q     <= 1'b0;
      fail_q     <= 1'b0;
      fail_idx_q <= '0;
      spur_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      req_q      <= req_d;
      busy_q     <= (state_d == StPing);
      fail_q     <= fail_d;
      fail_idx_q <= fail_idx_d;
      spur_q     <= spur_d;
    end
  end

  assign ping_req_o  = req_q;
  assign busy_o      = busy_q;
  assign ping_fail_o = fail_q;
  assign fail_idx_o  = fail_idx_q;
  assign spurious_o  = spur_q;

endmodule
